// File: rtl/uart_matrix_token_parser_if.sv
// Byte stream from the UART receiver into the token parser, and element stream from the parser
// towards matrix storage. The parser takes the slave view; its environment takes the master view.
interface uart_matrix_token_parser_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] elem_data;
    logic              elem_valid;
    logic              elem_ready;

    modport master (
        output rx_data, rx_valid, elem_ready,
        input  rx_ready, elem_data, elem_valid
    );

    modport slave (
        input  rx_data, rx_valid, elem_ready,
        output rx_ready, elem_data, elem_valid
    );
endinterface

// File: rtl/uart_matrix_token_parser.sv
// ASCII command parser: tokenises signed decimal numbers from the UART byte stream and turns them into
// matrix dimensions, an element stream, generator settings or an operand id depending on the command mode.
module uart_matrix_token_parser #(
    parameter int DATA_W  = 8,
    parameter int DIM_W   = 3,
    parameter int MAX_DIM = 5,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_matrix_token_parser_if.slave  bus,
    input  logic [1:0]                 mode_sel,
    input  logic                       start,
    output logic [DIM_W-1:0]           dim_m,
    output logic [DIM_W-1:0]           dim_n,
    output logic [DATA_W-1:0]          elem_min,
    output logic [DATA_W-1:0]          elem_max,
    output logic [CNT_W-1:0]           count,
    output logic [CNT_W-1:0]           matrix_id,
    output logic                       done,
    output logic                       busy,
    output logic                       err,
    output logic [2:0]                 err_code
);
    localparam int ACC_W0 = (DATA_W > CNT_W) ? DATA_W : CNT_W;
    localparam int ACC_W  = (ACC_W0 > DIM_W) ? ACC_W0 : DIM_W;
    localparam int WIDE_W = ACC_W + 4;
    localparam int TOT_W  = 2 * DIM_W;
    localparam logic [WIDE_W-1:0] LIM_POS = WIDE_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic [WIDE_W-1:0] LIM_NEG = WIDE_W'(2 ** (DATA_W - 1));
    localparam logic [WIDE_W-1:0] LIM_DIM = WIDE_W'((2 ** DIM_W) - 1);
    localparam logic [WIDE_W-1:0] LIM_CNT = WIDE_W'((2 ** CNT_W) - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_GET_M, S_GET_N, S_GET_ELEM, S_GET_CNT,
        S_GET_MIN, S_GET_MAX, S_GET_ID, S_DONE, S_ERR
    } state_e;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00, MODE_INPUT = 2'b01, MODE_GEN = 2'b10, MODE_SELECT = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        E_NONE = 3'd0, E_BAD_CHAR = 3'd1, E_OVERFLOW = 3'd2,
        E_DIM_RANGE = 3'd3, E_BAD_MINUS = 3'd4, E_MIN_MAX = 3'd5
    } err_e;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               dig_q, dig_d;
    logic [DIM_W-1:0]   dim_m_q, dim_m_d, dim_n_q, dim_n_d;
    logic [DATA_W-1:0]  elem_data_q, elem_data_d;
    logic               elem_valid_q, elem_valid_d;
    logic [DATA_W-1:0]  elem_min_q, elem_min_d, elem_max_q, elem_max_d;
    logic [CNT_W-1:0]   count_q, count_d, matrix_id_q, matrix_id_d;
    logic [TOT_W-1:0]   elem_cnt_q, elem_cnt_d;
    logic [2:0]         err_code_q, err_code_d;

    logic               byte_fire, elem_fire, is_digit, is_minus, is_sep, signed_field;
    logic               tok_done, err_hit;
    err_e               err_sel;
    logic [WIDE_W-1:0]  acc_wide, limit;
    logic [DATA_W-1:0]  tok_s;
    logic [TOT_W-1:0]   total;

    assign bus.rx_ready  = ~elem_valid_q;
    assign byte_fire     = bus.rx_valid & ~elem_valid_q;
    assign elem_fire     = elem_valid_q & bus.elem_ready;
    assign is_digit      = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_minus      = (bus.rx_data == 8'h2D);
    assign is_sep        = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) ||
                           (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h2C);
    assign signed_field  = (state_q == S_GET_ELEM) || (state_q == S_GET_MIN) || (state_q == S_GET_MAX);
    assign acc_wide      = WIDE_W'(acc_q) * WIDE_W'(10) + WIDE_W'(bus.rx_data[3:0]);
    assign tok_s         = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign total         = TOT_W'(dim_m_q) * TOT_W'(dim_n_q);

    // Magnitude ceiling for the field being parsed; a negative signed value may reach one further.
    always_comb begin
        case (state_q)
            S_GET_M, S_GET_N:   limit = LIM_DIM;
            S_GET_CNT, S_GET_ID: limit = LIM_CNT;
            default:            limit = neg_q ? LIM_NEG : LIM_POS;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets its default first, so no path through this block can infer a latch.
        state_d      = state_q;
        mode_d       = mode_q;
        acc_d        = acc_q;
        neg_d        = neg_q;
        dig_d        = dig_q;
        dim_m_d      = dim_m_q;
        dim_n_d      = dim_n_q;
        elem_data_d  = elem_data_q;
        elem_valid_d = elem_valid_q & ~bus.elem_ready;
        elem_min_d   = elem_min_q;
        elem_max_d   = elem_max_q;
        count_d      = count_q;
        matrix_id_d  = matrix_id_q;
        elem_cnt_d   = elem_cnt_q;
        err_code_d   = err_code_q;
        tok_done     = 1'b0;
        err_hit      = 1'b0;
        err_sel      = E_NONE;

        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                neg_d = 1'b0;
                dig_d = 1'b0;
                if (start && (mode_sel != 2'b00)) begin
                    mode_d     = mode_e'(mode_sel);
                    elem_cnt_d = '0;
                    state_d    = (mode_e'(mode_sel) == MODE_SELECT) ? S_GET_ID : S_GET_M;
                end
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default: begin
                if ((state_q == S_GET_ELEM) && elem_fire) begin
                    elem_cnt_d = elem_cnt_q + TOT_W'(1);
                    if (elem_cnt_d == total) state_d = S_DONE;
                end
                if (byte_fire) begin
                    if (is_digit) begin
                        if (acc_wide > limit) begin
                            err_hit = 1'b1;
                            err_sel = E_OVERFLOW;
                        end else begin
                            acc_d = acc_wide[ACC_W-1:0];
                            dig_d = 1'b1;
                        end
                    end else if (is_minus) begin
                        if (!signed_field || dig_q || neg_q) begin
                            err_hit = 1'b1;
                            err_sel = E_BAD_MINUS;
                        end else begin
                            neg_d = 1'b1;
                        end
                    end else if (is_sep) begin
                        // A lone minus before a separator is a malformed signed token.
                        if (dig_q) begin
                            tok_done = 1'b1;
                        end else if (neg_q) begin
                            err_hit = 1'b1;
                            err_sel = E_BAD_MINUS;
                        end
                    end else begin
                        err_hit = 1'b1;
                        err_sel = E_BAD_CHAR;
                    end
                end
            end
        endcase

        if (tok_done) begin
            acc_d = '0;
            neg_d = 1'b0;
            dig_d = 1'b0;
            case (state_q)
                S_GET_M, S_GET_N: begin
                    if ((acc_q == '0) || (acc_q > ACC_W'(MAX_DIM))) begin
                        err_hit = 1'b1;
                        err_sel = E_DIM_RANGE;
                    end else if (state_q == S_GET_M) begin
                        dim_m_d = acc_q[DIM_W-1:0];
                        state_d = S_GET_N;
                    end else begin
                        dim_n_d    = acc_q[DIM_W-1:0];
                        elem_cnt_d = '0;
                        state_d    = (mode_q == MODE_GEN) ? S_GET_CNT : S_GET_ELEM;
                    end
                end
                S_GET_ELEM: begin
                    elem_data_d  = tok_s;
                    elem_valid_d = 1'b1;
                end
                S_GET_CNT: begin
                    count_d = acc_q[CNT_W-1:0];
                    state_d = S_GET_MIN;
                end
                S_GET_MIN: begin
                    elem_min_d = tok_s;
                    state_d    = S_GET_MAX;
                end
                S_GET_MAX: begin
                    if ($signed(elem_min_q) > $signed(tok_s)) begin
                        err_hit = 1'b1;
                        err_sel = E_MIN_MAX;
                    end else begin
                        elem_max_d = tok_s;
                        state_d    = S_DONE;
                    end
                end
                S_GET_ID: begin
                    matrix_id_d = acc_q[CNT_W-1:0];
                    state_d     = S_DONE;
                end
                default: ;
            endcase
        end

        if (err_hit) begin
            state_d    = S_ERR;
            err_code_d = err_sel;
            acc_d      = '0;
            neg_d      = 1'b0;
            dig_d      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_NONE;
            acc_q        <= '0;
            neg_q        <= 1'b0;
            dig_q        <= 1'b0;
            dim_m_q      <= '0;
            dim_n_q      <= '0;
            elem_data_q  <= '0;
            elem_valid_q <= 1'b0;
            elem_min_q   <= '0;
            elem_max_q   <= DATA_W'(9);
            count_q      <= '0;
            matrix_id_q  <= '0;
            elem_cnt_q   <= '0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            neg_q        <= neg_d;
            dig_q        <= dig_d;
            dim_m_q      <= dim_m_d;
            dim_n_q      <= dim_n_d;
            elem_data_q  <= elem_data_d;
            elem_valid_q <= elem_valid_d;
            elem_min_q   <= elem_min_d;
            elem_max_q   <= elem_max_d;
            count_q      <= count_d;
            matrix_id_q  <= matrix_id_d;
            elem_cnt_q   <= elem_cnt_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.elem_data  = elem_data_q;
    assign bus.elem_valid = elem_valid_q;
    assign dim_m          = dim_m_q;
    assign dim_n          = dim_n_q;
    assign elem_min       = elem_min_q;
    assign elem_max       = elem_max_q;
    assign count          = count_q;
    assign matrix_id      = matrix_id_q;
    assign err_code       = err_code_q;
    assign done           = (state_q == S_DONE);
    assign err            = (state_q == S_ERR);
    assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_matrix_token_parser.sv
// Self-checking bench for uart_matrix_token_parser: elements are scoreboarded through a queue,
// command results (done/err, dims, generator settings, id) are compared after each command ends.
module tb_uart_matrix_token_parser;
    localparam int DATA_W = 8;
    localparam int DIM_W  = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode_sel;
    logic              start;
    logic [DIM_W-1:0]  dim_m, dim_n;
    logic [DATA_W-1:0] elem_min, elem_max;
    logic [CNT_W-1:0]  count, matrix_id;
    logic              done, busy, err;
    logic [2:0]        err_code;

    uart_matrix_token_parser_if #(.DATA_W(DATA_W)) bus ();

    uart_matrix_token_parser #(
        .DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_DIM(5), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .mode_sel(mode_sel), .start(start),
        .dim_m(dim_m), .dim_n(dim_n), .elem_min(elem_min), .elem_max(elem_max),
        .count(count), .matrix_id(matrix_id), .done(done), .busy(busy), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int err_seen = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: pulses are counted and every element handshake is popped and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_seen++;
            if (err) err_seen++;
            if (bus.elem_valid && bus.elem_ready) begin
                if (exp_q.size() == 0) begin
                    check("elem_extra", 32'(bus.elem_data), 32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("elem_data", 32'(bus.elem_data), 32'(mon_exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        while (!bus.rx_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic start_cmd(input logic [1:0] mode);
        mode_sel = mode;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input int d0, input int e0, input logic [2:0] exp_code);
        int n;
        n = 0;
        while (done_seen == d0 && err_seen == e0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check({tag, "_timeout"}, 32'(done_seen + err_seen), 32'(d0 + e0 + 1));
        repeat (4) tick();
        check({tag, "_done"}, 32'(done_seen - d0), (exp_code == 3'd0) ? 32'd1 : 32'd0);
        check({tag, "_err"}, 32'(err_seen - e0), (exp_code == 3'd0) ? 32'd0 : 32'd1);
        if (exp_code != 3'd0) check({tag, "_code"}, 32'(err_code), 32'(exp_code));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] mode, input string s, input logic [2:0] exp_code);
        int d0, e0;
        d0 = done_seen;
        e0 = err_seen;
        start_cmd(mode);
        send_str(s);
        finish_cmd(tag, d0, e0, exp_code);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.elem_ready = 1'b1;
        mode_sel       = 2'b00;
        start          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_elem_max", 32'(elem_max), 32'd9);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_dims", 32'({dim_m, dim_n}), 32'd0);
        rst_n = 1'b1;
        tick();

        // start with mode 00 does nothing
        start_cmd(2'b00);
        check("mode_none_busy", 32'(busy), 32'd0);

        // INPUT 2x3 with the first-element latency probed
        for (int v = 1; v <= 6; v++) exp_q.push_back(DATA_W'(v));
        d0 = done_seen;
        e0 = err_seen;
        start_cmd(2'b01);
        send_str("2 3 1");
        send_byte(8'h20);
        check("elem_latency_valid", 32'(bus.elem_valid), 32'd1);
        check("elem_latency_data", 32'(bus.elem_data), 32'd1);
        send_str("2 3 4 5 6\n");
        finish_cmd("in23", d0, e0, 3'd0);
        check("in23_dim_m", 32'(dim_m), 32'd2);
        check("in23_dim_n", 32'(dim_n), 32'd3);

        // signed extremes and redundant separators
        exp_q.push_back(DATA_W'(-5));
        exp_q.push_back(DATA_W'(127));
        exp_q.push_back(DATA_W'(0));
        exp_q.push_back(DATA_W'(-128));
        run_cmd("in22s", 2'b01, "2,2 -5 127  0 -128 ", 3'd0);

        // back-pressure: element held, rx blocked, stray bytes dropped
        bus.elem_ready = 1'b0;
        for (int v = 1; v <= 4; v++) exp_q.push_back(DATA_W'(v));
        d0 = done_seen;
        e0 = err_seen;
        start_cmd(2'b01);
        send_str("2 2 1 ");
        repeat (10) tick();
        check("bp_valid", 32'(bus.elem_valid), 32'd1);
        check("bp_data", 32'(bus.elem_data), 32'd1);
        check("bp_rx_ready", 32'(bus.rx_ready), 32'd0);
        bus.rx_data  = 8'h39;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_data  = 8'h2C;
        tick();
        bus.rx_valid = 1'b0;
        check("bp_hold", 32'(bus.elem_data), 32'd1);
        bus.elem_ready = 1'b1;
        send_str("2 3 4 ");
        finish_cmd("bp", d0, e0, 3'd0);

        // largest legal dimension
        for (int v = 1; v <= 5; v++) exp_q.push_back(DATA_W'(v));
        run_cmd("in51", 2'b01, "5 1 1 2 3 4 5 ", 3'd0);

        // GEN settings
        run_cmd("gen", 2'b10, "3 3 2 -4 9\r", 3'd0);
        check("gen_dims", 32'({dim_m, dim_n}), 32'({3'd3, 3'd3}));
        check("gen_count", 32'(count), 32'd2);
        check("gen_min", 32'(elem_min), 32'(8'hFC));
        check("gen_max", 32'(elem_max), 32'd9);
        run_cmd("gen_lim", 2'b10, "1 1 15 -128 127 ", 3'd0);
        check("gen_lim_count", 32'(count), 32'd15);
        check("gen_lim_min", 32'(elem_min), 32'(8'h80));
        check("gen_lim_max", 32'(elem_max), 32'(8'h7F));
        run_cmd("gen_minmax", 2'b10, "3 3 2 9 1 ", 3'd5);

        // error codes, then a clean command
        run_cmd("err_dim", 2'b01, "6 2 ", 3'd3);
        run_cmd("err_dim0", 2'b01, "0 ", 3'd3);
        run_cmd("err_char", 2'b01, "2 x", 3'd1);
        run_cmd("err_ovf", 2'b01, "2 2 300 ", 3'd2);
        run_cmd("err_minus", 2'b01, "-2 ", 3'd4);
        exp_q.push_back(DATA_W'(7));
        run_cmd("recover", 2'b01, "1 1 7 ", 3'd0);
        check("recover_dims", 32'({dim_m, dim_n}), 32'({3'd1, 3'd1}));
        check("recover_err_code_held", 32'(err_code), 32'd4);

        // SELECT
        run_cmd("sel", 2'b11, "12 ", 3'd0);
        check("sel_id", 32'(matrix_id), 32'd12);

        // reset mid-element
        bus.elem_ready = 1'b0;
        start_cmd(2'b01);
        send_str("2 2 5 ");
        tick();
        check("mid_valid", 32'(bus.elem_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_valid", 32'(bus.elem_valid), 32'd0);
        check("mr_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("mr_elem_data", 32'(bus.elem_data), 32'd0);
        check("mr_dims", 32'({dim_m, dim_n}), 32'd0);
        check("mr_gen", 32'({count, elem_min, elem_max}), 32'({4'd0, 8'd0, 8'd9}));
        check("mr_id", 32'(matrix_id), 32'd0);
        check("mr_err_code", 32'(err_code), 32'd0);
        check("mr_pulses", 32'({done, err}), 32'd0);
        bus.elem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        run_cmd("post_rst_sel", 2'b11, "3 ", 3'd0);
        check("post_rst_id", 32'(matrix_id), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
